// File: rtl/shift_pkg.sv
// Shared definitions for the shift-out controller slice.
//   state_t        : controller states (IDLE, SHIFT, LATCH)
//   DEF_WIDTH      : default bits per frame
//   DEF_DIV_LOG2   : default log2 of the serial bit period in clk cycles
//   clog2()        : constant-evaluable ceiling log2, used to size counters
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 24;
  localparam int DEF_DIV_LOG2 = 3;

  // Ceiling log2 for value >= 2; returns the bit count needed to hold value-1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_out_controller_phase_gen.sv
// Serial-clock phase generator.
// A DIV_LOG2-bit phase counter P that advances while enabled and is forced
// to 0 by a synchronous clear.
//   clk, reset   : system clock, asynchronous active-high reset
//   en           : advance P this cycle
//   clr          : force P to 0 at the next edge (wins over en)
//   ser_clk_next : serial clock level for the phase P will hold after this edge
//   bit_end      : one-cycle tick while enabled and P == D-1 (last phase of a bit)
module shift_phase_gen #(
  parameter int DIV_LOG2 = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic ser_clk_next,
  output logic bit_end
);

  logic [DIV_LOG2-1:0] phase;
  logic [DIV_LOG2-1:0] phase_inc;

  assign phase_inc = phase + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase_inc;
    end
  end

  // With H = D/2, "P >= H" is simply the MSB of the phase. Looking at the
  // incremented value lets the caller register ser_clk in step with P.
  assign ser_clk_next = phase_inc[DIV_LOG2-1];
  assign bit_end      = en && (phase == '1);

endmodule

// File: rtl/shift_out_controller.sv
// Shift-out controller: serialises one WIDTH-bit frame MSB-first into an
// external shift-register chain, then pulses the chain's storage latch.
//   clk, reset          : system clock, asynchronous active-high reset
//   req_valid/req_data  : frame offer; bit WIDTH-1 goes out first
//   req_ready           : high in IDLE; frame taken on valid & ready
//   abort               : synchronous cancel of the frame in flight
//   ser_data, ser_clk   : serial data and shift clock (chain samples on rise)
//   ser_latch           : storage latch strobe, high for H cycles
//   busy                : frame in flight (SHIFT or LATCH)
//   done                : one-cycle pulse after a frame has been latched
// Serial bit period is D = 2^DIV_LOG2 clk cycles, half period H = D/2.
module shift_out_controller
  import shift_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DIV_LOG2 = DEF_DIV_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  input  logic             abort,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy,
  output logic             done
);

  localparam int BW = clog2(WIDTH);
  localparam int H  = 2 ** (DIV_LOG2 - 1);
  localparam logic [BW-1:0]       LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DIV_LOG2-1:0] LAT_LAST = DIV_LOG2'(H - 1);

  state_t              state, state_d;
  logic [WIDTH-1:0]    sreg, sreg_d;
  logic [BW-1:0]       bit_cnt, bit_cnt_d;
  logic [DIV_LOG2-1:0] lat_cnt, lat_cnt_d;
  logic                ser_data_d, ser_clk_d, ser_latch_d, busy_d, done_d;

  logic phase_en, phase_clr, ser_clk_next, bit_end;

  // P only runs inside SHIFT; any cycle that is not SHIFT-to-SHIFT parks it at 0
  // so every frame starts on phase 0.
  assign phase_en  = (state == SHIFT);
  assign phase_clr = (state != SHIFT) || (state_d != SHIFT);

  shift_phase_gen #(
    .DIV_LOG2(DIV_LOG2)
  ) u_phase_gen (
    .clk          (clk),
    .reset        (reset),
    .en           (phase_en),
    .clr          (phase_clr),
    .ser_clk_next (ser_clk_next),
    .bit_end      (bit_end)
  );

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    sreg_d      = sreg;
    bit_cnt_d   = bit_cnt;
    lat_cnt_d   = lat_cnt;
    ser_data_d  = ser_data;
    ser_clk_d   = ser_clk;
    ser_latch_d = 1'b0;
    done_d      = 1'b0;

    case (state)
      IDLE: begin
        ser_data_d = 1'b0;
        ser_clk_d  = 1'b0;
        // abort has no effect here; req_ready is implied by being in IDLE.
        if (req_valid) begin
          sreg_d     = req_data;
          bit_cnt_d  = '0;
          lat_cnt_d  = '0;
          ser_data_d = req_data[WIDTH-1];
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d    = IDLE;
          sreg_d     = '0;
          bit_cnt_d  = '0;
          ser_data_d = 1'b0;
          ser_clk_d  = 1'b0;
        end else begin
          ser_clk_d = ser_clk_next;
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              state_d     = LATCH;
              ser_data_d  = 1'b0;
              ser_clk_d   = 1'b0;
              ser_latch_d = 1'b1;
              lat_cnt_d   = '0;
            end else begin
              // Data moves only as P wraps to 0, a half period ahead of the rise.
              sreg_d     = {sreg[WIDTH-2:0], 1'b0};
              ser_data_d = sreg[WIDTH-2];
              bit_cnt_d  = bit_cnt + 1'b1;
            end
          end
        end
      end

      LATCH: begin
        ser_data_d = 1'b0;
        ser_clk_d  = 1'b0;
        if (abort) begin
          // abort beats the final latch cycle: no done.
          state_d   = IDLE;
          sreg_d    = '0;
          bit_cnt_d = '0;
          lat_cnt_d = '0;
        end else if (lat_cnt == LAT_LAST) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          sreg_d    = '0;
          bit_cnt_d = '0;
          lat_cnt_d = '0;
        end else begin
          ser_latch_d = 1'b1;
          lat_cnt_d   = lat_cnt + 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        ser_data_d = 1'b0;
        ser_clk_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // The async reset clears every output flop at once, so a latch pulse in
  // progress is cut immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sreg      <= sreg_d;
      bit_cnt   <= bit_cnt_d;
      lat_cnt   <= lat_cnt_d;
      ser_data  <= ser_data_d;
      ser_clk   <= ser_clk_d;
      ser_latch <= ser_latch_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_out_controller.sv
// Bench for shift_out_controller. Three instances cover the default
// configuration (24 bits, D=8), a small one (8 bits, D=4) and the minimum
// one (2 bits, D=2). A negedge monitor rebuilds each frame from ser_clk rises
// and checks it, plus latch/done timing, against a queue of expected frames.
module tb_shift_out_controller;

  typedef struct {
    int          inst;
    logic [23:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  valid;
  logic [2:0]  abrt;
  logic [2:0]  ready, sd, sc, sl, busy, done;
  logic [23:0] data0;
  logic [7:0]  data1;
  logic [1:0]  data2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Per-instance monitor state.
  int          w_of[3] = '{24, 8, 2};
  int          d_of[3] = '{8, 4, 2};
  logic [23:0] acc[3];
  int          nbits[3];
  int          lat_first[3];
  int          lat_n[3];
  int          k_of[3];
  int          done_cyc[3];
  logic        prev_sc[3];
  logic [3:0]  sc_pat[3];
  logic [3:0]  sd_pat[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_out_controller #(.WIDTH(24), .DIV_LOG2(3)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_data(data0),
    .req_ready(ready[0]), .abort(abrt[0]), .ser_data(sd[0]), .ser_clk(sc[0]),
    .ser_latch(sl[0]), .busy(busy[0]), .done(done[0])
  );

  shift_out_controller #(.WIDTH(8), .DIV_LOG2(2)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_data(data1),
    .req_ready(ready[1]), .abort(abrt[1]), .ser_data(sd[1]), .ser_clk(sc[1]),
    .ser_latch(sl[1]), .busy(busy[1]), .done(done[1])
  );

  shift_out_controller #(.WIDTH(2), .DIV_LOG2(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .req_valid(valid[2]), .req_data(data2),
    .req_ready(ready[2]), .abort(abrt[2]), .ser_data(sd[2]), .ser_clk(sc[2]),
    .ser_latch(sl[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Cycle numbering: the period ending at edge n is cycle n.
  always @(negedge clk) begin
    int now;
    exp_t e;
    now = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        acc[i] = '0; nbits[i] = 0; lat_n[i] = 0; prev_sc[i] = 1'b0;
      end else begin
        check($sformatf("busy_vs_ready%0d", i), busy[i], !ready[i]);
        if (sc[i] && !prev_sc[i]) begin
          acc[i]   = {acc[i][22:0], sd[i]};
          nbits[i] = nbits[i] + 1;
        end
        if (sl[i]) begin
          if (lat_n[i] == 0) lat_first[i] = now;
          lat_n[i] = lat_n[i] + 1;
        end
        if (now >= k_of[i] + 1 && now <= k_of[i] + 4) begin
          sc_pat[i][now-k_of[i]-1] = sc[i];
          sd_pat[i][now-k_of[i]-1] = sd[i];
        end
        if (done[i]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("done_inst%0d", i), i, e.inst);
            check($sformatf("frame_data%0d", i), acc[i], e.data);
            check($sformatf("rise_count%0d", i), nbits[i], w_of[i]);
            check($sformatf("latch_start%0d", i), lat_first[i], k_of[i] + w_of[i]*d_of[i] + 1);
            check($sformatf("latch_len%0d", i), lat_n[i], d_of[i]/2);
            check($sformatf("done_cycle%0d", i), now, k_of[i] + w_of[i]*d_of[i] + d_of[i]/2 + 1);
          end
          done_cyc[i] = now;
        end
        if (ready[i]) begin
          acc[i] = '0; nbits[i] = 0; lat_n[i] = 0;
          if (valid[i]) k_of[i] = now;
        end
        prev_sc[i] = sc[i];
      end
    end
  end

  // All stimulus runs at posedge+1.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int inst, input logic [23:0] v, input bit hold);
    exp_t e;
    int   n;
    case (inst)
      0:       data0 = v;
      1:       data1 = v[7:0];
      default: data2 = v[1:0];
    endcase
    valid[inst] = 1'b1;
    e.inst = inst;
    e.data = v;
    exp_q.push_back(e);
    n = 0;
    while (!ready[inst] && n < 500) begin
      step(1);
      n++;
    end
    check("accept_ready", ready[inst], 1'b1);
    step(1);
    if (!hold) valid[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget);
    int n;
    n = 0;
    while (!done[inst] && n < budget) begin
      step(1);
      n++;
    end
    check($sformatf("done_seen%0d", inst), done[inst], 1'b1);
    step(1);
  endtask

  initial begin
    int rises;
    logic psc;
    for (int i = 0; i < 3; i++) begin
      k_of[i] = -100; done_cyc[i] = -1; prev_sc[i] = 1'b0;
      acc[i] = '0; nbits[i] = 0; lat_n[i] = 0; lat_first[i] = -1;
      sc_pat[i] = '0; sd_pat[i] = '0;
    end
    rst = 3'b111; valid = '0; abrt = '0; data0 = '0; data1 = '0; data2 = '0;

    #2;
    check("rst_ready", ready, 3'b111);
    check("rst_busy", busy, 3'b000);
    check("rst_ser", {sd, sc, sl, done}, 12'h000);
    #20 rst = 3'b000;

    // Default configuration: handshake on edge 10.
    while (cyc < 9) step(1);
    send(0, 24'hA50F81, 1'b0);
    check("t1_k", k_of[0], 10);
    wait_done(0, 400);
    check("t1_latch_first", lat_first[0], 203);
    check("t1_done_cyc", done_cyc[0], 207);

    // Back-to-back frames with valid held.
    send(1, 24'h3C, 1'b1);
    send(1, 24'hC3, 1'b0);
    check("b2b_accept_on_done", k_of[1], done_cyc[1]);
    wait_done(1, 100);

    // Abort during the 5th rising ser_clk.
    step(3);
    send(1, 24'h5A, 1'b0);
    rises = 0;
    psc = 1'b0;
    for (int n = 0; n < 100 && rises < 5; n++) begin
      if (sc[1] && !psc) rises++;
      psc = sc[1];
      if (rises < 5) step(1);
    end
    check("abort_rise5", rises, 5);
    abrt[1] = 1'b1;
    step(1);
    abrt[1] = 1'b0;
    void'(exp_q.pop_back());
    check("abort_idle", ready[1], 1'b1);
    check("abort_outs", {busy[1], sc[1], sd[1], sl[1], done[1]}, 5'b0);
    step(50);
    send(1, 24'hFF, 1'b0);
    wait_done(1, 100);

    // valid pulsed while busy must be ignored.
    send(1, 24'h96, 1'b0);
    step(6);
    check("busy_not_ready", ready[1], 1'b0);
    data1 = 8'h00;
    valid[1] = 1'b1;
    step(3);
    valid[1] = 1'b0;
    wait_done(1, 100);
    step(10);

    // Asynchronous reset in the middle of LATCH.
    send(1, 24'h81, 1'b0);
    for (int n = 0; n < 100 && !sl[1]; n++) step(1);
    check("latch_reached", sl[1], 1'b1);
    @(negedge clk);
    #2 rst[1] = 1'b1;
    #1;
    check("rst_mid_latch", {sl[1], busy[1], sc[1], done[1]}, 4'b0);
    check("rst_mid_ready", ready[1], 1'b1);
    void'(exp_q.pop_back());
    step(2);
    rst[1] = 1'b0;
    step(60);
    check("rst_release_ready", ready[1], 1'b1);

    // Minimum configuration: WIDTH=2, D=2, frame 2'b10.
    send(2, 24'h2, 1'b0);
    wait_done(2, 40);
    check("min_ser_clk_pattern", sc_pat[2], 4'b1010);
    check("min_ser_data_pattern", sd_pat[2], 4'b0011);
    check("min_done_k6", done_cyc[2], k_of[2] + 6);

    step(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
